// File: rtl/logic_unit_arbiter.sv
// Round-robin arbiter sharing one bitwise logic unit (OR/AND/XOR/NOR) among NUM_REQ requesters.
// Define LOGIC_ARB_BACK2BACK_EN to allow a new grant in the same cycle a result is consumed.
module logic_unit_arbiter #(
    parameter int unsigned NUM_REQ = 2,
    parameter int unsigned WIDTH   = 64,
    parameter int unsigned ID_W    = 2
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [NUM_REQ-1:0]       req_valid,
    output logic [NUM_REQ-1:0]       req_ready,
    input  logic [NUM_REQ*WIDTH-1:0] req_a,
    input  logic [NUM_REQ*WIDTH-1:0] req_b,
    input  logic [NUM_REQ*2-1:0]     req_op,
    output logic                     resp_valid,
    input  logic                     resp_ready,
    output logic [WIDTH-1:0]         resp_data,
    output logic [ID_W-1:0]          resp_id
);

    localparam int unsigned PTR_W = ID_W + 1;

    localparam logic [1:0] OP_OR  = 2'b00;
    localparam logic [1:0] OP_AND = 2'b01;
    localparam logic [1:0] OP_XOR = 2'b10;
    localparam logic [1:0] OP_NOR = 2'b11;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RESP = 1'b1
    } state_e;

    state_e            state_q, state_d;
    logic [ID_W-1:0]   rr_ptr_q, rr_ptr_d;
    logic [WIDTH-1:0]  resp_data_q, resp_data_d;
    logic [ID_W-1:0]   resp_id_q, resp_id_d;

    logic              arb_en_c;
    logic [NUM_REQ-1:0] gnt_c;
    logic              gnt_any_c;
    logic [ID_W-1:0]   gnt_idx_c;
    logic [WIDTH-1:0]  a_sel_c;
    logic [WIDTH-1:0]  b_sel_c;
    logic [1:0]        op_sel_c;
    logic [WIDTH-1:0]  result_c;

    // Arbitration window; forced closed while reset is asserted so req_ready stays low.
    always_comb begin
        arb_en_c = 1'b0;
        if (rst_n) begin
`ifdef LOGIC_ARB_BACK2BACK_EN
            arb_en_c = (state_q == ST_IDLE) || resp_ready;
`else
            arb_en_c = (state_q == ST_IDLE);
`endif
        end
    end

    // Round-robin scan starting at rr_ptr; first valid requester wins.
    always_comb begin
        logic [PTR_W-1:0] scan;
        logic             found;
        gnt_c     = '0;
        gnt_idx_c = '0;
        found     = 1'b0;
        scan      = '0;
        for (int unsigned k = 0; k < NUM_REQ; k++) begin
            scan = PTR_W'(rr_ptr_q) + PTR_W'(k);
            if (scan >= PTR_W'(NUM_REQ)) begin
                scan = scan - PTR_W'(NUM_REQ);
            end
            for (int unsigned i = 0; i < NUM_REQ; i++) begin
                if (arb_en_c && !found && (scan == PTR_W'(i)) && req_valid[i]) begin
                    gnt_c[i]  = 1'b1;
                    gnt_idx_c = ID_W'(i);
                    found     = 1'b1;
                end
            end
        end
        gnt_any_c = found;
    end

    // Operand mux driven by the one-hot grant so non-granted inputs never propagate.
    always_comb begin
        a_sel_c  = '0;
        b_sel_c  = '0;
        op_sel_c = OP_OR;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            if (gnt_c[i]) begin
                a_sel_c  = req_a[i*WIDTH +: WIDTH];
                b_sel_c  = req_b[i*WIDTH +: WIDTH];
                op_sel_c = req_op[i*2 +: 2];
            end
        end
    end

    // Shared bitwise logic unit.
    always_comb begin
        result_c = '0;
        case (op_sel_c)
            OP_OR:   result_c = a_sel_c | b_sel_c;
            OP_AND:  result_c = a_sel_c & b_sel_c;
            OP_XOR:  result_c = a_sel_c ^ b_sel_c;
            OP_NOR:  result_c = ~(a_sel_c | b_sel_c);
            default: result_c = '0;
        endcase
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic; a grant in RESP only occurs when back-to-back mode is built in.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (gnt_any_c) begin
                    state_d = ST_RESP;
                end
            end
            ST_RESP: begin
                if (resp_ready) begin
                    state_d = gnt_any_c ? ST_RESP : ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Result, owner id and round-robin pointer update on a handshake only.
    always_comb begin
        rr_ptr_d    = rr_ptr_q;
        resp_data_d = resp_data_q;
        resp_id_d   = resp_id_q;
        if (gnt_any_c) begin
            resp_data_d = result_c;
            resp_id_d   = gnt_idx_c;
            rr_ptr_d    = (gnt_idx_c == ID_W'(NUM_REQ - 1)) ? '0 : gnt_idx_c + ID_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rr_ptr_q    <= '0;
            resp_data_q <= '0;
            resp_id_q   <= '0;
        end else begin
            rr_ptr_q    <= rr_ptr_d;
            resp_data_q <= resp_data_d;
            resp_id_q   <= resp_id_d;
        end
    end

    // Outputs.
    always_comb begin
        req_ready  = gnt_c;
        resp_valid = (state_q == ST_RESP);
        resp_data  = resp_data_q;
        resp_id    = resp_id_q;
    end

endmodule

// File: tb/tb_logic_unit_arbiter.sv
// Scoreboard bench for logic_unit_arbiter: a cycle model predicts grants and queues expected results.
`timescale 1ns/1ps
module tb_logic_unit_arbiter;

    localparam int NUM_REQ = 2;
    localparam int WIDTH   = 64;
    localparam int ID_W    = 2;
`ifdef LOGIC_ARB_BACK2BACK_EN
    localparam bit B2B      = 1'b1;
    localparam int THRU_CYC = 17;
    localparam int BP_LAT   = 1;
`else
    localparam bit B2B      = 1'b0;
    localparam int THRU_CYC = 32;
    localparam int BP_LAT   = 2;
`endif

    logic                     clk = 1'b0;
    logic                     rst_n = 1'b0;
    logic [NUM_REQ-1:0]       req_valid;
    logic [NUM_REQ-1:0]       req_ready;
    logic [NUM_REQ*WIDTH-1:0] req_a;
    logic [NUM_REQ*WIDTH-1:0] req_b;
    logic [NUM_REQ*2-1:0]     req_op;
    logic                     resp_valid;
    logic                     resp_ready;
    logic [WIDTH-1:0]         resp_data;
    logic [ID_W-1:0]          resp_id;

    always #5 clk = ~clk;

    logic_unit_arbiter #(.NUM_REQ(NUM_REQ), .WIDTH(WIDTH), .ID_W(ID_W)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_a      (req_a),
        .req_b      (req_b),
        .req_op     (req_op),
        .resp_valid (resp_valid),
        .resp_ready (resp_ready),
        .resp_data  (resp_data),
        .resp_id    (resp_id)
    );

    int n_vec = 0;
    int n_err = 0;
    int cyc   = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic logic [63:0] lu_ref(input logic [1:0] op, input logic [63:0] a,
                                           input logic [63:0] b);
        case (op)
            2'b00:   return a | b;
            2'b01:   return a & b;
            2'b10:   return a ^ b;
            default: return ~(a | b);
        endcase
    endfunction

    // Reference model: predicts grant and response each cycle, sampled on the falling edge.
    bit                       m_busy = 1'b0;
    int                       m_rr   = 0;
    int                       m_done = 0;
    logic [ID_W+WIDTH-1:0]    sb[$];
    int                       glog[$];

    always @(negedge clk) begin : model
        logic [NUM_REQ-1:0] exp_rdy;
        int                 w;
        int                 idx;
        bit                 en;
        if (!rst_n) begin
            m_busy = 1'b0;
            m_rr   = 0;
            sb.delete();
            check("rst_valid", 64'(resp_valid), 64'd0);
            check("rst_ready", 64'(req_ready), 64'd0);
            check("rst_data", resp_data, 64'd0);
            check("rst_id", 64'(resp_id), 64'd0);
        end else begin
            check("resp_valid", 64'(resp_valid), 64'(m_busy));
            if (m_busy && sb.size() > 0) begin
                check("resp_data", resp_data, sb[0][WIDTH-1:0]);
                check("resp_id", 64'(resp_id), 64'(sb[0][ID_W+WIDTH-1:WIDTH]));
            end
            en      = !m_busy || (B2B && resp_ready);
            exp_rdy = '0;
            w       = -1;
            if (en) begin
                for (int k = 0; k < NUM_REQ; k++) begin
                    idx = (m_rr + k) % NUM_REQ;
                    if (w < 0 && req_valid[idx]) begin
                        w            = idx;
                        exp_rdy[idx] = 1'b1;
                    end
                end
            end
            check("req_ready", 64'(req_ready), 64'(exp_rdy));
            if (m_busy && resp_ready) begin
                void'(sb.pop_front());
                m_busy = 1'b0;
                m_done++;
            end
            if (w >= 0) begin
                sb.push_back({ID_W'(w), lu_ref(req_op[w*2 +: 2], req_a[w*WIDTH +: WIDTH],
                                               req_b[w*WIDTH +: WIDTH])});
                m_busy = 1'b1;
                m_rr   = (w + 1) % NUM_REQ;
                glog.push_back(w);
            end
        end
    end

    // Present a request on requester i and hold it until granted.
    task automatic issue(input int i, input logic [63:0] a, input logic [63:0] b,
                         input logic [1:0] op);
        int t;
        req_valid[i]           = 1'b1;
        req_a[i*WIDTH +: WIDTH] = a;
        req_b[i*WIDTH +: WIDTH] = b;
        req_op[i*2 +: 2]        = op;
        t = 0;
        do begin
            @(negedge clk);
            t++;
        end while (!req_ready[i] && t < 50);
        check("issue_grant", 64'(req_ready[i]), 64'd1);
        @(posedge clk);
        #1;
        req_valid[i] = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [63:0] t2_exp [4];
        int          t;
        int          base;
        int          dbase;
        int          t_start;
        logic [63:0] a;
        logic [63:0] b;

        t2_exp[0] = 64'h0000_0000_0000_FFFF;
        t2_exp[1] = 64'h0000_0000_0000_0000;
        t2_exp[2] = 64'h0000_0000_0000_FFFF;
        t2_exp[3] = 64'hFFFF_FFFF_FFFF_0000;

        req_valid  = '0;
        req_a      = '0;
        req_b      = '0;
        req_op     = '0;
        resp_ready = 1'b0;

        // Reset held with random inputs.
        rst_n = 1'b0;
        repeat (6) begin
            @(posedge clk);
            #1;
            req_valid  = NUM_REQ'($urandom);
            req_a      = {$urandom, $urandom, $urandom, $urandom};
            req_b      = {$urandom, $urandom, $urandom, $urandom};
            req_op     = 4'($urandom);
            resp_ready = 1'($urandom);
        end
        @(posedge clk);
        #1;
        req_valid  = '0;
        resp_ready = 1'b1;
        rst_n      = 1'b1;

        // Single requests, one per opcode.
        for (int k = 0; k < 4; k++) begin
            issue(0, 64'h00FF, 64'hFF00, 2'(k));
            @(negedge clk);
            check("t2_valid", 64'(resp_valid), 64'd1);
            check("t2_data", resp_data, t2_exp[k]);
            check("t2_id", 64'(resp_id), 64'd0);
            @(posedge clk);
            #1;
        end

        // Fairness with both requesters continuously valid.
        base  = glog.size();
        dbase = m_done;
        req_a  = {64'h0000_0000_0000_00C3, 64'h0000_0000_0000_00A5};
        req_b  = {64'h0000_0000_0000_003C, 64'h0000_0000_0000_005A};
        req_op = 4'b0110;
        req_valid = 2'b11;
        t = 0;
        while (m_done < dbase + 8 && t < 100) begin
            @(posedge clk);
            t++;
        end
        #1;
        req_valid = '0;
        check("t3_done", 64'(m_done >= dbase + 8), 64'd1);
        if (glog.size() >= base + 8) begin
            for (int j = base + 1; j < base + 8; j++) begin
                check("t3_alt", 64'(glog[j]), 64'(1 - glog[j-1]));
            end
        end
        repeat (3) @(posedge clk);
        #1;

        // Backpressure while requester 1 is pending.
        resp_ready = 1'b0;
        issue(0, 64'h0F0F, 64'h00FF, 2'b10);
        req_valid[1]        = 1'b1;
        req_a[2*WIDTH-1:WIDTH] = 64'h3;
        req_b[2*WIDTH-1:WIDTH] = 64'h4;
        req_op[3:2]         = 2'b00;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            check("t4_ready", 64'(req_ready), 64'd0);
            check("t4_data", resp_data, 64'h0FF0);
            check("t4_id", 64'(resp_id), 64'd0);
        end
        @(posedge clk);
        #1;
        resp_ready = 1'b1;
        t = 0;
        do begin
            @(negedge clk);
            t++;
        end while (!req_ready[1] && t < 10);
        check("t4_grant1", 64'(req_ready[1]), 64'd1);
        check("t4_lat", 64'(t), 64'(BP_LAT));
        @(posedge clk);
        #1;
        req_valid[1] = 1'b0;
        @(negedge clk);
        check("t4_data1", resp_data, 64'h7);
        check("t4_id1", 64'(resp_id), 64'd1);
        repeat (2) @(posedge clk);
        #1;

        // Reset while a result is held.
        resp_ready = 1'b0;
        issue(0, 64'h1234, 64'h0, 2'b00);
        @(negedge clk);
        check("t5_valid", 64'(resp_valid), 64'd1);
        check("t5_data", resp_data, 64'h1234);
        #2;
        rst_n = 1'b0;
        #1;
        check("t5_async", 64'(resp_valid), 64'd0);
        repeat (2) @(posedge clk);
        #1;
        rst_n      = 1'b1;
        resp_ready = 1'b1;
        repeat (4) begin
            @(negedge clk);
            check("t5_nores", 64'(resp_valid), 64'd0);
        end
        repeat (2) @(posedge clk);
        #1;

        // Throughput: 16 back-to-back requests from requester 0.
        t_start = cyc;
        for (int k = 0; k < 16; k++) begin
            a = 64'($urandom_range(0, 255));
            b = 64'($urandom_range(0, 255));
            issue(0, a, b, 2'(k));
        end
        t = 0;
        do begin
            @(negedge clk);
            t++;
        end while (!(resp_valid && resp_ready) && t < 10);
        @(posedge clk);
        #1;
        check("t6_cycles", 64'(cyc - t_start), 64'(THRU_CYC));

        repeat (3) @(posedge clk);
        #1;
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
